flag_sequencer: RTL
===================

FLAG_SEQUENCER -- requirements
Module: flag_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_FLAGS, 82: number of selectable flags; legal range 1..255.
- INIT_IDX, 0: flag index selected after reset.
- DWELL_FRAMES, 180: frames a flag is shown before auto-advance; legal range 1..4095.
- WIPE_STEP, 32: wipe advance in pixels per frame; 0 means instant switch.
- H_ACTIVE, 640: active pixels per line.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: pixel clock.
- rst_n, in, 1: reset; one clock, reset asynchronous, active-low.
- frame_start, in, 1: single-cycle pulse once per frame, during vblank.
- pix_x, in, 10: current pixel column.
- video_active, in, 1: high inside the visible area.
- next, in, 1: single-cycle request to advance to the next flag.
- prev, in, 1: single-cycle request to go back to the previous flag.
- auto_en, in, 1: enables timed auto-advance.
- load, in, 1: single-cycle request for a direct jump.
- load_idx, in, 8: target index for load.
- cur_color, in, 6: flag-bank colour for cur_sel at pix_x.
- nxt_color, in, 6: flag-bank colour for nxt_sel at pix_x.
- cur_sel, out, 8: index of the displayed flag.
- nxt_sel, out, 8: index of the incoming flag.
- color, out, 6: registered RGB222 pixel.
- busy, out, 1: high while a wipe is in progress.
- count, out, 8: constant NUM_FLAGS.

Function
REQ-003 The block SHALL implement two states, SHOW and WIPE; nxt_sel SHALL equal cur_sel in SHOW.
REQ-004 A one-deep pending register SHALL capture requests on any cycle.
- Priority: load > next > prev.
- next and prev asserted together with no load SHALL be ignored.
- A later request SHALL overwrite an earlier one still pending.
REQ-005 Target computation:
- next: cur_sel+1, wrapping NUM_FLAGS-1 to 0.
- prev: cur_sel-1, wrapping 0 to NUM_FLAGS-1.
- The target SHALL be computed from cur_sel at the moment the pending request is applied, not at capture.
REQ-006 load with load_idx >= NUM_FLAGS SHALL be dropped.
- A pending request whose target equals cur_sel SHALL be cleared without starting a wipe.
REQ-007 Pending requests SHALL be applied only on frame_start in SHOW; requests arriving during WIPE SHALL stay pending until the first frame_start after the commit.
REQ-008 On an applied request with WIPE_STEP>0:
- nxt_sel <= target, wipe_x <= WIPE_STEP, state <= WIPE, busy <= 1.
- Pending SHALL be cleared.
REQ-009 On frame_start in WIPE:
- If wipe_x+WIPE_STEP >= H_ACTIVE: cur_sel <= nxt_sel, wipe_x <= 0, state <= SHOW, busy <= 0.
- Otherwise: wipe_x <= wipe_x+WIPE_STEP.
- wipe_x SHALL be 11 bits wide so the sum cannot overflow.
REQ-010 With WIPE_STEP=0, an applied request SHALL set cur_sel and nxt_sel to the target on the same frame_start; WIPE SHALL never be entered.
REQ-011 Dwell counter (12 bits):
- Increments on frame_start in SHOW while auto_en=1 and nothing is pending.
- Held at 0 while auto_en=0.
- Cleared whenever a switch is applied.
- On reaching DWELL_FRAMES-1 at a frame_start, it SHALL generate an internal next request, pending at the following frame_start.
REQ-012 color SHALL be registered with 1-cycle latency from pix_x, video_active, cur_color and nxt_color:
- 0 when video_active=0.
- Otherwise nxt_color when state=WIPE and pix_x < wipe_x.
- Otherwise cur_color.
REQ-013 count SHALL be combinational constant NUM_FLAGS[7:0].

Reset
REQ-014 While rst_n=0, all outputs and state SHALL take these values immediately, without waiting for a clock edge:
- cur_sel = nxt_sel = INIT_IDX, color = 0, busy = 0.
- state = SHOW, wipe_x = 0, dwell = 0, pending cleared.
REQ-015 Reset asserted mid-wipe SHALL abandon the wipe.
- No partial commit of nxt_sel SHALL occur.
- The first frame_start after release SHALL behave as in SHOW.

Verification
REQ-016 next pulse, then frame_start (defaults) -> nxt_sel=1, busy=1.
- After the next 18 frame_starts, busy=1.
- On the 19th, cur_sel=1 and busy=0.
- During wipe frame 1, pix_x=31 shows nxt_color and pix_x=32 shows cur_color, each one cycle later.
REQ-017 Wrap:
- From cur_sel=81, next -> target 0.
- From cur_sel=0, prev -> target 81.
- next+prev in the same cycle -> no change.
REQ-018 Request during WIPE:
- load_idx=40 arriving mid-wipe toward 1 -> first cur_sel=1.
- The next frame_start then starts a wipe to 40.
- load_idx=82 -> ignored.
REQ-019 auto_en=1 with DWELL_FRAMES=3, WIPE_STEP=0 -> cur_sel increments every 4 frame_starts.
- auto_en=0 -> cur_sel holds indefinitely.
REQ-020 Reset pulse mid-wipe:
- Immediately cur_sel=INIT_IDX, busy=0, color=0.
- video_active=0 -> color=0 regardless of cur_color=6'h3F.

Source files
------------

// File: rtl/flag_sequencer.sv
// Flag selector with frame-synchronous request queueing, timed auto-advance and a left-to-right wipe.
// color is registered (1 cycle after pix_x); requests are held one-deep until a frame_start in SHOW.
module flag_sequencer #(
    parameter int NUM_FLAGS    = 82,
    parameter int INIT_IDX     = 0,
    parameter int DWELL_FRAMES = 180,
    parameter int WIPE_STEP    = 32,
    parameter int H_ACTIVE     = 640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [9:0] pix_x,
    input  logic       video_active,
    input  logic       next,
    input  logic       prev,
    input  logic       auto_en,
    input  logic       load,
    input  logic [7:0] load_idx,
    input  logic [5:0] cur_color,
    input  logic [5:0] nxt_color,
    output logic [7:0] cur_sel,
    output logic [7:0] nxt_sel,
    output logic [5:0] color,
    output logic       busy,
    output logic [7:0] count
);

    typedef enum logic {SHOW, WIPE} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_LOAD, REQ_NEXT, REQ_PREV} req_t;

    localparam logic [7:0]  NUM8       = 8'(NUM_FLAGS);
    localparam logic [7:0]  LAST_IDX   = 8'(NUM_FLAGS - 1);
    localparam logic [7:0]  INIT8      = 8'(INIT_IDX);
    localparam logic [10:0] STEP       = 11'(WIPE_STEP);
    localparam logic [10:0] HACT       = 11'(H_ACTIVE);
    localparam logic [11:0] DWELL_LAST = 12'(DWELL_FRAMES - 1);

    state_t      state, state_d;
    req_t        pend, pend_d;
    logic [7:0]  pend_idx, pend_idx_d;
    logic [7:0]  cur_d, nxt_d;
    logic [10:0] wipe_x, wipe_d, wipe_sum;
    logic [11:0] dwell, dwell_d;
    logic        busy_d;
    logic [7:0]  target;

    assign count = NUM8;

    // Target is resolved against the current selection at apply time, not at capture.
    always_comb begin
        target = cur_sel;
        case (pend)
            REQ_LOAD: target = pend_idx;
            REQ_NEXT: target = (cur_sel == LAST_IDX) ? 8'd0 : cur_sel + 8'd1;
            REQ_PREV: target = (cur_sel == 8'd0) ? LAST_IDX : cur_sel - 8'd1;
            default:  target = cur_sel;
        endcase
    end

    always_comb begin
        state_d    = state;
        pend_d     = pend;
        pend_idx_d = pend_idx;
        cur_d      = cur_sel;
        nxt_d      = nxt_sel;
        wipe_d     = wipe_x;
        dwell_d    = dwell;
        busy_d     = busy;
        wipe_sum   = wipe_x + STEP;

        if (frame_start) begin
            if (state == SHOW) begin
                if (pend != REQ_NONE) begin
                    pend_d = REQ_NONE;
                    if (target != cur_sel) begin
                        dwell_d = '0;
                        if (WIPE_STEP == 0) begin
                            cur_d = target;
                            nxt_d = target;
                        end else begin
                            nxt_d   = target;
                            wipe_d  = STEP;
                            state_d = WIPE;
                            busy_d  = 1'b1;
                        end
                    end
                end else if (auto_en) begin
                    if (dwell == DWELL_LAST) begin
                        pend_d = REQ_NEXT;
                    end else begin
                        dwell_d = dwell + 12'd1;
                    end
                end
            end else begin
                if (wipe_sum >= HACT) begin
                    cur_d   = nxt_sel;
                    wipe_d  = '0;
                    state_d = SHOW;
                    busy_d  = 1'b0;
                end else begin
                    wipe_d = wipe_sum;
                end
            end
        end

        if (!auto_en) begin
            dwell_d = '0;
        end

        // A fresh user request overrides whatever is pending, including an auto-advance.
        if (load) begin
            if (load_idx < NUM8) begin
                pend_d     = REQ_LOAD;
                pend_idx_d = load_idx;
            end
        end else if (next && !prev) begin
            pend_d = REQ_NEXT;
        end else if (prev && !next) begin
            pend_d = REQ_PREV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SHOW;
            pend     <= REQ_NONE;
            pend_idx <= '0;
            cur_sel  <= INIT8;
            nxt_sel  <= INIT8;
            wipe_x   <= '0;
            dwell    <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            pend     <= pend_d;
            pend_idx <= pend_idx_d;
            cur_sel  <= cur_d;
            nxt_sel  <= nxt_d;
            wipe_x   <= wipe_d;
            dwell    <= dwell_d;
            busy     <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color <= '0;
        end else if (!video_active) begin
            color <= '0;
        end else if (state == WIPE && {1'b0, pix_x} < wipe_x) begin
            color <= nxt_color;
        end else begin
            color <= cur_color;
        end
    end

endmodule
